// File: rtl/des_axi_pkg.sv
// rtl/des_axi_pkg.sv - shared register map, bit positions and FSM types for the DES AXI register file
package des_axi_pkg;

  localparam int CTRL_IDX    = 0;
  localparam int STATUS_IDX  = 1;
  localparam int IN_BASE_IDX = 2;

  localparam int START_BIT  = 0;
  localparam int IRQ_EN_BIT = 1;
  localparam int MODE_BIT   = 2;

  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic int out_base_idx(input int num_in_words);
    return IN_BASE_IDX + num_in_words;
  endfunction

endpackage

// File: rtl/des_axi_lite_if.sv
// rtl/des_axi_lite_if.sv - AXI4-Lite write/read handshake FSMs feeding a simple word-indexed register port
module des_axi_lite_if
  import des_axi_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [AW-1:0]     awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [AW-1:0]     araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [DW-1:0]     rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              wr_en_o,
  output logic [AW-3:0]     wr_idx_o,
  output logic [DW-1:0]     wr_data_o,
  output logic [DW/8-1:0]   wr_strb_o,
  output logic              rd_en_o,
  output logic [AW-3:0]     rd_idx_o,
  input  logic [DW-1:0]     rd_data_i
);

  wr_state_e       w_state_q;
  rd_state_e       r_state_q;
  logic            awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic            aw_held_q, w_held_q;
  logic [AW-3:0]   awidx_q;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic [DW/8-1:0] wstrb_q;
  logic            aw_take, w_take, aw_have, w_have, ar_take;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^{awaddr_i[1:0], araddr_i[1:0]};

  assign aw_take = awvalid_i & awready_q;
  assign w_take  = wvalid_i & wready_q;
  assign aw_have = aw_held_q | aw_take;
  assign w_have  = w_held_q | w_take;
  assign ar_take = arvalid_i & arready_q;

  // The commit fires on the edge where the second half of the write arrives, bypassing the hold regs.
  assign wr_en_o   = (w_state_q == W_IDLE) & aw_have & w_have;
  assign wr_idx_o  = aw_take ? awaddr_i[AW-1:2] : awidx_q;
  assign wr_data_o = w_take ? wdata_i : wdata_q;
  assign wr_strb_o = w_take ? wstrb_i : wstrb_q;
  assign rd_en_o   = ar_take;
  assign rd_idx_o  = araddr_i[AW-1:2];

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = RESP_OKAY;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = RESP_OKAY;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_take) awidx_q <= awaddr_i[AW-1:2];
          if (w_take) begin
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
          end
          if (aw_have && w_have) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end else begin
            aw_held_q <= aw_have;
            w_held_q  <= w_have;
            awready_q <= !aw_have;
            wready_q  <= !w_have;
          end
        end
        W_RESP: begin
          if (bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_take) begin
            rdata_q   <= rd_data_i;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready_i) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/des_axi_regfile.sv
// rtl/des_axi_regfile.sv - AXI4-Lite register file with start/busy/done handshake to the DES core
module des_axi_regfile
  import des_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_IN_WORDS       = 4,
  parameter int NUM_OUT_WORDS      = 2
) (
  input  logic                                        s00_axi_aclk,
  input  logic                                        s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               s00_axi_awaddr,
  input  logic                                        s00_axi_awvalid,
  output logic                                        s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]               s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             s00_axi_wstrb,
  input  logic                                        s00_axi_wvalid,
  output logic                                        s00_axi_wready,
  output logic [1:0]                                  s00_axi_bresp,
  output logic                                        s00_axi_bvalid,
  input  logic                                        s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               s00_axi_araddr,
  input  logic                                        s00_axi_arvalid,
  output logic                                        s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               s00_axi_rdata,
  output logic [1:0]                                  s00_axi_rresp,
  output logic                                        s00_axi_rvalid,
  input  logic                                        s00_axi_rready,
  output logic                                        core_start,
  output logic                                        core_mode,
  output logic [C_S_AXI_DATA_WIDTH*NUM_IN_WORDS-1:0]  core_din,
  input  logic                                        core_done,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_OUT_WORDS-1:0] core_dout,
  output logic                                        irq
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int IW       = C_S_AXI_ADDR_WIDTH - 2;
  localparam int OUT_BASE = out_base_idx(NUM_IN_WORDS);

  logic            wr_en, rd_en;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic [DW-1:0]   wr_data, rd_data;
  logic [DW/8-1:0] wr_strb;
  int              wr_word, rd_word;

  logic            irq_en_q, mode_q, busy_q, done_q, start_q, irq_q;
  logic [DW-1:0]   in_q  [NUM_IN_WORDS];
  logic [DW-1:0]   out_q [NUM_OUT_WORDS];
  logic            ctrl_wr, start_req, done_clr, done_set;

  des_axi_lite_if #(
    .AW(C_S_AXI_ADDR_WIDTH),
    .DW(DW)
  ) u_if (
    .clk_i     (s00_axi_aclk),
    .resetn_i  (s00_axi_aresetn),
    .awaddr_i  (s00_axi_awaddr),
    .awvalid_i (s00_axi_awvalid),
    .awready_o (s00_axi_awready),
    .wdata_i   (s00_axi_wdata),
    .wstrb_i   (s00_axi_wstrb),
    .wvalid_i  (s00_axi_wvalid),
    .wready_o  (s00_axi_wready),
    .bresp_o   (s00_axi_bresp),
    .bvalid_o  (s00_axi_bvalid),
    .bready_i  (s00_axi_bready),
    .araddr_i  (s00_axi_araddr),
    .arvalid_i (s00_axi_arvalid),
    .arready_o (s00_axi_arready),
    .rdata_o   (s00_axi_rdata),
    .rresp_o   (s00_axi_rresp),
    .rvalid_o  (s00_axi_rvalid),
    .rready_i  (s00_axi_rready),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .rd_en_o   (rd_en),
    .rd_idx_o  (rd_idx),
    .rd_data_i (rd_data)
  );

  assign wr_word = int'(wr_idx);
  assign rd_word = int'(rd_idx);

  // Control and status live in byte 0 only, so their side effects are gated by strobe 0.
  assign ctrl_wr   = wr_en && (wr_word == CTRL_IDX) && wr_strb[0];
  assign start_req = ctrl_wr && wr_data[START_BIT] && !busy_q;
  assign done_clr  = wr_en && (wr_word == STATUS_IDX) && wr_strb[0] && wr_data[DONE_BIT];
  assign done_set  = core_done && busy_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      irq_en_q <= 1'b0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_IN_WORDS; i++) in_q[i] <= '0;
      for (int j = 0; j < NUM_OUT_WORDS; j++) out_q[j] <= '0;
    end else begin
      start_q <= start_req;
      irq_q   <= done_q & irq_en_q;
      if (ctrl_wr) begin
        irq_en_q <= wr_data[IRQ_EN_BIT];
        mode_q   <= wr_data[MODE_BIT];
      end
      for (int i = 0; i < NUM_IN_WORDS; i++) begin
        if (wr_en && (wr_word == IN_BASE_IDX + i)) begin
          for (int b = 0; b < DW/8; b++) begin
            if (wr_strb[b]) in_q[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      // Completion outranks a same-cycle W1C; start and completion never coincide since they need opposite BUSY.
      if (done_set) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        for (int j = 0; j < NUM_OUT_WORDS; j++) out_q[j] <= core_dout[DW*j +: DW];
      end else if (start_req) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end else if (done_clr) begin
        done_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      if (rd_word == CTRL_IDX) begin
        rd_data[IRQ_EN_BIT] = irq_en_q;
        rd_data[MODE_BIT]   = mode_q;
      end else if (rd_word == STATUS_IDX) begin
        rd_data[BUSY_BIT] = busy_q;
        rd_data[DONE_BIT] = done_q;
      end
      for (int i = 0; i < NUM_IN_WORDS; i++) begin
        if (rd_word == IN_BASE_IDX + i) rd_data = in_q[i];
      end
      for (int j = 0; j < NUM_OUT_WORDS; j++) begin
        if (rd_word == OUT_BASE + j) rd_data = out_q[j];
      end
    end
  end

  for (genvar g = 0; g < NUM_IN_WORDS; g++) begin : g_din
    assign core_din[DW*g +: DW] = in_q[g];
  end

  assign core_start = start_q;
  assign core_mode  = mode_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_des_axi_regfile.sv
// tb/tb_des_axi_regfile.sv - directed self-checking bench for des_axi_regfile
module tb_des_axi_regfile;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [5:0]   awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         core_start, core_mode, core_done, irq;
  logic [127:0] core_din;
  logic [63:0]  core_dout;

  int total = 0;
  int bad = 0;
  int starts = 0;
  int s0;
  logic [1:0] br;
  logic to;

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start) starts++;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  des_axi_regfile dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .core_start      (core_start),
    .core_mode       (core_mode),
    .core_din        (core_din),
    .core_done       (core_done),
    .core_dout       (core_dout),
    .irq             (irq)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic pulse_done, input logic [63:0] dout,
                           output logic [1:0] resp, output logic tmo);
    bit aw_ok, w_ok, aw_r, w_r;
    int n;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    if (pulse_done) begin
      core_done = 1'b1;
      core_dout = dout;
    end
    aw_ok = 0; w_ok = 0; n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      aw_r = awready; w_r = wready;
      @(posedge clk); #1;
      core_done = 1'b0;
      if (aw_r) begin aw_ok = 1; awvalid = 1'b0; end
      if (w_r) begin w_ok = 1; wvalid = 1'b0; end
      n++;
      if (!(aw_ok && w_ok)) @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    tmo = !(aw_ok && w_ok) || !bvalid;
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    logic t;
    axi_write(a, d, s, 1'b0, 64'h0, r, t);
    chk(tag, {t, r}, 3'b000);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp, output logic tmo);
    bit ok;
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1; ok = 0; n = 0;
    while (!ok && n < 20) begin
      ok = arready;
      @(posedge clk); #1;
      n++;
      if (ok) arvalid = 1'b0;
      else @(negedge clk);
    end
    arvalid = 1'b0; n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    tmo = !ok || !rvalid;
    d = rdata;
    resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] r;
    logic t;
    axi_read(a, d, r, t);
    chk(tag, {t, r, d}, {1'b0, 2'b00, exp});
  endtask

  initial begin
    aresetn = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; core_done = 1'b0; core_dout = '0;

    // reset state
    repeat (10) @(negedge clk);
    chk("rst_outs", {awready, wready, bvalid, arready, rvalid, core_start, core_mode, irq, bresp, rresp}, 0);
    chk("rst_din", core_din, 0);
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) rchk($sformatf("rst_rd%0d", i), 6'(i * 4), 32'h0);

    // IN write/readback and core_din packing
    for (int i = 0; i < 4; i++) wr($sformatf("in_wr%0d", i), 6'(8 + 4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) rchk($sformatf("in_rd%0d", i), 6'(8 + 4 * i), 32'(i + 1));
    chk("din_pack", core_din, {32'h4, 32'h3, 32'h2, 32'h1});

    // byte strobes
    wr("strb_wr", 6'h08, 32'hAABBCCDD, 4'b0010);
    rchk("strb_rd", 6'h08, 32'h0000CC01);

    // W presented three cycles ahead of AW
    @(negedge clk);
    wdata = 32'h5A5A0001; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wfirst_nob", bvalid, 1'b0);
    awaddr = 6'h0C; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_b", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("wfirst_bdone", bvalid, 1'b0);
    rchk("wfirst_rd", 6'h0C, 32'h5A5A0001);

    // start with IRQ_EN, then completion
    s0 = starts;
    wr("ctrl_start", 6'h00, 32'h3, 4'hF);
    chk("start_once", starts - s0, 1);
    chk("mode_enc", core_mode, 1'b0);
    rchk("status_busy", 6'h04, 32'h1);
    rchk("ctrl_rd", 6'h00, 32'h2);
    @(negedge clk);
    core_done = 1'b1; core_dout = 64'h85E81354_0F0AB405;
    @(negedge clk);
    core_done = 1'b0;
    chk("irq_lat", irq, 1'b0);
    @(negedge clk);
    chk("irq_set", irq, 1'b1);
    rchk("out0", 6'h18, 32'h0F0AB405);
    rchk("out1", 6'h1C, 32'h85E81354);
    rchk("status_done", 6'h04, 32'h2);

    // W1C of DONE lands on the same edge as core_done: set wins
    s0 = starts;
    wr("ctrl_start2", 6'h00, 32'h3, 4'hF);
    chk("start2_once", starts - s0, 1);
    rchk("status_busy2", 6'h04, 32'h1);
    axi_write(6'h04, 32'h2, 4'hF, 1'b1, 64'h11112222_33334444, br, to);
    chk("race_b", {to, br}, 3'b000);
    rchk("race_status", 6'h04, 32'h2);
    rchk("race_out0", 6'h18, 32'h33334444);

    // START while BUSY is ignored but MODE still updates
    s0 = starts;
    wr("ctrl_start3", 6'h00, 32'h1, 4'hF);
    wr("ctrl_busy", 6'h00, 32'h5, 4'hF);
    chk("busy_nostart", starts - s0, 1);
    chk("mode_dec", core_mode, 1'b1);
    rchk("status_busy3", 6'h04, 32'h1);
    rchk("ctrl_rd2", 6'h00, 32'h4);

    // read backpressure
    @(negedge clk);
    araddr = 6'h0C; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {rvalid, rdata}, {1'b1, 32'h5A5A0001});
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    chk("bp_release", rvalid, 1'b0);

    // read-only and unmapped words
    wr("out_wr", 6'h18, 32'hDEADBEEF, 4'hF);
    rchk("out_ro", 6'h18, 32'h33334444);
    wr("unmap_wr", 6'h24, 32'h12345678, 4'hF);
    rchk("unmap_rd", 6'h24, 32'h0);

    // completion while busy, then a stray one while idle
    @(negedge clk);
    core_done = 1'b1; core_dout = 64'h00000001_00000002;
    @(negedge clk);
    core_done = 1'b1; core_dout = 64'hFFFFFFFF_FFFFFFFF;
    @(negedge clk);
    core_done = 1'b0;
    rchk("idle_done0", 6'h18, 32'h2);
    rchk("idle_done1", 6'h1C, 32'h1);

    // reset mid-operation clears state and a late core_done is ignored
    wr("ctrl_start4", 6'h00, 32'h3, 4'hF);
    @(negedge clk);
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_outs", {awready, bvalid, arready, rvalid, irq, core_start}, 0);
    aresetn = 1'b1;
    @(negedge clk);
    core_done = 1'b1; core_dout = 64'hFFFFFFFF_FFFFFFFF;
    @(negedge clk);
    core_done = 1'b0;
    rchk("rst2_status", 6'h04, 32'h0);
    rchk("rst2_out0", 6'h18, 32'h0);
    rchk("rst2_in1", 6'h0C, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_axi_regfile.md
Name: des_axi_regfile

Overview:
Parametrised AXI4-Lite slave register file fronting the DES core. It generalises the fixed four-register peripheral to configurable input and output word counts. It adds a start/busy/done handshake to the core, a mode bit, W1C done status, byte strobes and a level interrupt. It sits between the AXI interconnect and the DES datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must cover (2+NUM_IN_WORDS+NUM_OUT_WORDS)*4.
NUM_IN_WORDS, 4, writable input words (key then plaintext).
NUM_OUT_WORDS, 2, read-only result words.

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  synchronous active-low reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awvalid/awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid/wready  in/out  1  W handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid/bready  out/in  1  B handshake
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arvalid/arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid/rready  out/in  1  R handshake
core_start  out  1  one-cycle start pulse
core_mode  out  1  0 = encrypt, 1 = decrypt
core_din  out  32*NUM_IN_WORDS  input words; word 0 is in the LSBs
core_done  in  1  one-cycle completion pulse
core_dout  in  32*NUM_OUT_WORDS  result, valid in the core_done cycle
irq  out  1  interrupt, active high

Behaviour:
- Clock and reset: one clock, s00_axi_aclk. Reset is synchronous and active-low on s00_axi_aresetn.
- Reset values: all registers 0. All ready/valid outputs 0, core_start 0, irq 0, bresp/rresp 0.
- Register map (word index = addr[AW-1:2]):
  - 0: CTRL. Bit0 START (write 1 pulses, reads 0). Bit1 IRQ_EN. Bit2 MODE.
  - 1: STATUS. Bit0 BUSY (RO). Bit1 DONE (W1C).
  - 2..1+NUM_IN_WORDS: IN[i], RW.
  - next NUM_OUT_WORDS: OUT[j], RO.
- Decode errors: writes to RO or unmapped words are ignored with OKAY. Unmapped reads return 0 with OKAY.
- Write channel:
  - FSM W_IDLE/W_RESP. In W_IDLE, awready and wready are high. AW and W are captured independently in either order, each into a hold register.
  - When both are held, the register update happens on that edge. The block then enters W_RESP with bvalid=1 and both readies low.
  - bvalid stays high until bready; it then returns to W_IDLE.
  - Only one write is outstanding at a time.
  - wstrb is applied per byte. For CTRL and STATUS, only strobe byte 0 is honoured.
- Read channel:
  - FSM R_IDLE/R_DATA. arready is high in R_IDLE. On the AR handshake, rdata is registered and rvalid=1 next cycle.
  - rdata is held stable until rready.
  - Read latency is 1 cycle from the AR handshake to rvalid.
- Start:
  - A CTRL write with START=1 while BUSY=0 gives core_start=1 on the next cycle for exactly 1 cycle. In that same cycle BUSY goes to 1 and DONE goes to 0.
  - START while BUSY=1 is ignored; the other CTRL bits still update.
  - core_mode is CTRL.MODE, sampled by the core at core_start.
- Done:
  - core_done while BUSY=1 captures core_dout into OUT[] and sets BUSY=0, DONE=1.
  - core_done while BUSY=0 is ignored.
- Simultaneous events:
  - A W1C to DONE in the same cycle as core_done: the set wins, DONE=1.
  - IN writes while BUSY=1 are accepted; the core must latch core_din at start.
- Interrupt: irq = DONE & IRQ_EN, registered, 1-cycle latency.
- Reset mid-operation: BUSY, DONE and OUT[] are cleared. Any pending bvalid/rvalid is dropped. A late core_done is ignored.

Decomposition:
- Package des_axi_pkg holds:
  - register index localparams: CTRL_IDX, STATUS_IDX, IN_BASE_IDX.
  - CTRL bit positions: START_BIT, IRQ_EN_BIT, MODE_BIT.
  - STATUS bit positions.
  - RESP_OKAY.
  - function out_base_idx(NUM_IN_WORDS).
  - write and read FSM state enums.
- Sub-module des_axi_lite_if: owns the AXI handshake FSMs. It exposes wr_en/wr_idx/wr_data/wr_strb and rd_en/rd_idx/rd_data to the register core in des_axi_regfile.

Test Plan:
- Reset: hold aresetn=0 for 10 cycles -> all outputs 0. Reads of words 0..7 return 0.
- Register write/readback:
  - Write IN[0..3] = 0x01..0x04 with full strobes; reading back gives 0x01..0x04 and core_din = 0x00000004_00000003_00000002_00000001.
  - Write 0xAABBCCDD to IN[0] with wstrb=0b0010 over 0x00000001; readback gives 0x0000CC01.
- AW/W ordering: W presented 3 cycles before AW -> single bvalid after AW, bresp=0, register updated.
- Start/done:
  - Write CTRL=0x3 -> core_start high exactly 1 cycle and STATUS=0x1.
  - Drive core_done with core_dout=0x85E81354_0F0AB405 -> OUT[0]=0x0F0AB405, OUT[1]=0x85E81354, STATUS=0x2, irq=1 one cycle later.
- Done clear race: issue the W1C STATUS=0x2 write timed so the register update coincides with core_done -> DONE stays 1.
- Busy protection and backpressure:
  - Write CTRL=0x1 while BUSY -> no core_start.
  - Read with rready held low for 5 cycles -> rvalid and rdata stable throughout.
  - Write to OUT[0] -> bresp=0, value unchanged.
